// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: opcode/flags and memory handshakes in, all strobes out.
`timescale 1ns/1ps
interface multicycle_controller_if #(
    parameter int unsigned RETIRE_W = 16
);
    logic [5:0]          opcode;
    logic                c_flag;
    logic                z_flag;
    logic                imem_ready;
    logic                mem_ready;
    logic                imem_req;
    logic                ir_write;
    logic                pc_write;
    logic [2:0]          pc_src;
    logic [2:0]          alu_op;
    logic                alu_src_const;
    logic                rf_rd2_sel_rd;
    logic                rf_write_en;
    logic [2:0]          rf_in_sel;
    logic                mem_read;
    logic                mem_write;
    logic                flag_write;
    logic                flag_sel_shifter;
    logic                retire;
    logic [RETIRE_W-1:0] retired_count;
    logic                error;

    modport master (
        input  opcode, c_flag, z_flag, imem_ready, mem_ready,
        output imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_const, rf_rd2_sel_rd,
               rf_write_en, rf_in_sel, mem_read, mem_write, flag_write, flag_sel_shifter,
               retire, retired_count, error
    );

    modport slave (
        output opcode, c_flag, z_flag, imem_ready, mem_ready,
        input  imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_const, rf_rd2_sel_rd,
               rf_write_en, rf_in_sel, mem_read, mem_write, flag_write, flag_sel_shifter,
               retire, retired_count, error
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with ready handshakes, timeout trap
// and retired-instruction counter.
`timescale 1ns/1ps
module multicycle_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned RETIRE_W       = 16
) (
    input logic                    clk,
    input logic                    rst,
    multicycle_controller_if.master bus
);
    localparam logic [2:0] StFetch  = 3'd0;
    localparam logic [2:0] StDecode = 3'd1;
    localparam logic [2:0] StExec   = 3'd2;
    localparam logic [2:0] StMem    = 3'd3;
    localparam logic [2:0] StWb     = 3'd4;
    localparam logic [2:0] StError  = 3'd5;

    localparam int unsigned WaitW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] PcOffset = 3'b100;
    localparam logic [2:0] PcConst  = 3'b010;
    localparam logic [2:0] PcPlus1  = 3'b001;

    logic [2:0]          state_q, state_d;
    logic [WaitW-1:0]    wait_q, wait_d;
    logic [RETIRE_W-1:0] count_q;

    logic [5:0] op;
    logic is_ralu, is_ialu, is_alu, is_mem, is_load, is_store, is_rsvd;
    logic is_jump, is_branch, is_shift, taken, single, timeout_hit;
    logic unused_opcode_lsb;

    assign op                = bus.opcode;
    assign unused_opcode_lsb = op[0];
    assign is_ralu   = (op[5:4] == 2'b00);
    assign is_ialu   = (op[5:4] == 2'b01);
    assign is_alu    = is_ralu | is_ialu;
    assign is_mem    = (op[5:3] == 3'b100);
    assign is_load   = is_mem & (op[2:1] == 2'b00);
    assign is_store  = is_mem & (op[2:1] == 2'b01);
    assign is_rsvd   = is_mem & op[2];
    assign is_jump   = (op[5:3] == 3'b101);
    assign is_branch = (op[5:3] == 3'b110);
    assign is_shift  = (op[5:3] == 3'b111);
    assign single    = is_jump | is_branch | is_rsvd;

    always_comb begin
        case (op[2:1])
            2'b00:   taken = bus.z_flag;
            2'b01:   taken = ~bus.z_flag;
            2'b10:   taken = bus.c_flag;
            default: taken = ~bus.c_flag;
        endcase
    end

    // A zero limit disables the trap entirely.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_q == WaitW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        case (state_q)
            StFetch: begin
                if (bus.imem_ready)   state_d = StDecode;
                else if (timeout_hit) state_d = StError;
                else                  wait_d  = wait_q + 1'b1;
            end
            StDecode: state_d = single ? StFetch : StExec;
            StExec:   state_d = is_mem ? StMem : StWb;
            StMem: begin
                if (bus.mem_ready)    state_d = is_load ? StWb : StFetch;
                else if (timeout_hit) state_d = StError;
                else                  wait_d  = wait_q + 1'b1;
            end
            StWb:     state_d = StFetch;
            StError:  state_d = StError;
            default:  state_d = StFetch;
        endcase
    end

    logic       imem_req, ir_write, pc_write, alu_src_const, rf_rd2_sel_rd, rf_write_en;
    logic       mem_read, mem_write, flag_write, flag_sel_shifter, retire, error;
    logic [2:0] pc_src, alu_op, rf_in_sel;

    always_comb begin
        imem_req = 1'b0; ir_write = 1'b0; pc_write = 1'b0; pc_src = 3'b000;
        alu_op = 3'b000; alu_src_const = 1'b0; rf_rd2_sel_rd = 1'b0; rf_write_en = 1'b0;
        rf_in_sel = 3'b000; mem_read = 1'b0; mem_write = 1'b0; flag_write = 1'b0;
        flag_sel_shifter = 1'b0; retire = 1'b0; error = 1'b0;
        // EXEC datapath controls stay asserted through MEM and WB.
        if (state_q == StExec || state_q == StMem || state_q == StWb) begin
            alu_op        = is_alu ? op[3:1] : 3'b000;
            alu_src_const = is_ialu | is_mem;
            rf_rd2_sel_rd = is_store;
        end
        case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                ir_write = bus.imem_ready;
            end
            StDecode: begin
                if (single) begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    if (is_jump)                pc_src = PcConst;
                    else if (is_branch & taken) pc_src = PcOffset;
                    else                        pc_src = PcPlus1;
                end
            end
            StMem: begin
                mem_read  = is_load;
                mem_write = is_store;
                if (bus.mem_ready && is_store) begin
                    pc_write = 1'b1;
                    pc_src   = PcPlus1;
                    retire   = 1'b1;
                end
            end
            StWb: begin
                rf_write_en      = 1'b1;
                rf_in_sel        = is_load ? 3'b010 : (is_shift ? 3'b100 : 3'b001);
                flag_write       = ~is_load;
                flag_sel_shifter = is_shift;
                pc_write         = 1'b1;
                pc_src           = PcPlus1;
                retire           = 1'b1;
            end
            StError: error = 1'b1;
            default: ;
        endcase
        // Reset aborts immediately: nothing may be written on the reset edge.
        if (!rst) begin
            imem_req = 1'b0; ir_write = 1'b0; pc_write = 1'b0; pc_src = 3'b000;
            alu_op = 3'b000; alu_src_const = 1'b0; rf_rd2_sel_rd = 1'b0; rf_write_en = 1'b0;
            rf_in_sel = 3'b000; mem_read = 1'b0; mem_write = 1'b0; flag_write = 1'b0;
            flag_sel_shifter = 1'b0; retire = 1'b0; error = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) count_q <= count_q + 1'b1;
        end
    end

    assign bus.imem_req         = imem_req;
    assign bus.ir_write         = ir_write;
    assign bus.pc_write         = pc_write;
    assign bus.pc_src           = pc_src;
    assign bus.alu_op           = alu_op;
    assign bus.alu_src_const    = alu_src_const;
    assign bus.rf_rd2_sel_rd    = rf_rd2_sel_rd;
    assign bus.rf_write_en      = rf_write_en;
    assign bus.rf_in_sel        = rf_in_sel;
    assign bus.mem_read         = mem_read;
    assign bus.mem_write        = mem_write;
    assign bus.flag_write       = flag_write;
    assign bus.flag_sel_shifter = flag_sel_shifter;
    assign bus.retire           = retire;
    assign bus.retired_count    = rst ? count_q : '0;
    assign bus.error            = error;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected cycle sequences from a
// class-level model, compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_multicycle_controller;
    localparam int unsigned RW = 8;
    localparam int unsigned TO = 15;

    localparam int KR = 0, KI = 1, KLOAD = 2, KSTORE = 3, KRSVD = 4, KJUMP = 5, KBR = 6, KSH = 7;

    typedef struct packed {
        logic       imem_req;
        logic       ir_write;
        logic       pc_write;
        logic [2:0] pc_src;
        logic [2:0] alu_op;
        logic       alu_src_const;
        logic       rf_rd2_sel_rd;
        logic       rf_write_en;
        logic [2:0] rf_in_sel;
        logic       mem_read;
        logic       mem_write;
        logic       flag_write;
        logic       flag_sel_shifter;
        logic       retire;
        logic       error;
    } outs_t;

    typedef struct packed {
        outs_t         o;
        logic [RW-1:0] cnt;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if #(.RETIRE_W(RW)) bus ();

    multicycle_controller #(
        .TIMEOUT_CYCLES(TO),
        .RETIRE_W(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    rec_t          q[$];
    logic [RW-1:0] model_cnt = '0;
    logic [5:0]    cur_op = '0;
    logic          cur_c = 1'b0, cur_z = 1'b0;
    int            n_vec = 0, n_err = 0;
    int            cyc_since = 0, last_len = 0;
    logic [2:0]    last_pc_src = '0, last_rf_in_sel = '0;

    // Per-cycle comparison against the queued expectation, plus observations for literal checks.
    always @(negedge clk) begin
        outs_t got;
        rec_t  exp_r;
        got = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_op,
               bus.alu_src_const, bus.rf_rd2_sel_rd, bus.rf_write_en, bus.rf_in_sel,
               bus.mem_read, bus.mem_write, bus.flag_write, bus.flag_sel_shifter,
               bus.retire, bus.error};
        if (q.size() > 0) begin
            exp_r = q.pop_front();
            n_vec++;
            if (got !== exp_r.o || bus.retired_count !== exp_r.cnt) begin
                n_err++;
                $display("FAIL cycle_outputs t=%0t: got outs=%h count=%0d, want outs=%h count=%0d",
                         $time, got, bus.retired_count, exp_r.o, exp_r.cnt);
            end
        end
        if (!rst) begin
            cyc_since = 0;
        end else begin
            cyc_since++;
            if (bus.pc_write) last_pc_src = bus.pc_src;
            if (bus.rf_write_en) last_rf_in_sel = bus.rf_in_sel;
            if (bus.retire) begin
                last_len  = cyc_since;
                cyc_since = 0;
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic lit(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step(input logic rv, input logic ir, input logic mr, input outs_t o);
        rec_t r;
        @(posedge clk);
        #1;
        rst            = rv;
        bus.opcode     = cur_op;
        bus.c_flag     = cur_c;
        bus.z_flag     = cur_z;
        bus.imem_ready = ir;
        bus.mem_ready  = mr;
        if (!rv) begin
            r.o       = '0;
            r.cnt     = '0;
            model_cnt = '0;
        end else begin
            r.o   = o;
            r.cnt = model_cnt;
            if (o.retire) model_cnt = model_cnt + 1'b1;
        end
        q.push_back(r);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, rb(), rb(), '0);
    endtask

    task automatic error_tail();
        outs_t o;
        o       = '0;
        o.error = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, rb(), rb(), o);
    endtask

    // fdel/mdel: cycles without ready; >= TO means the trap fires. abort: reset during MEM.
    task automatic run_instr(input logic [5:0] op, input logic cf, input logic zf,
                             input int fdel, input int mdel, input bit abort);
        int    v, kind, fn;
        bit    taken;
        outs_t o, ex;
        v  = int'(op);
        fn = (v / 2) % 8;
        if (v < 16)      kind = KR;
        else if (v < 32) kind = KI;
        else if (v < 34) kind = KLOAD;
        else if (v < 36) kind = KSTORE;
        else if (v < 40) kind = KRSVD;
        else if (v < 48) kind = KJUMP;
        else if (v < 56) kind = KBR;
        else             kind = KSH;
        case ((v / 2) % 4)
            0:       taken = zf;
            1:       taken = !zf;
            2:       taken = cf;
            default: taken = !cf;
        endcase
        cur_op = op;
        cur_c  = cf;
        cur_z  = zf;

        o          = '0;
        o.imem_req = 1'b1;
        for (int i = 0; i < fdel && i < int'(TO); i++) step(1'b1, 1'b0, rb(), o);
        if (fdel >= int'(TO)) begin
            error_tail();
            return;
        end
        o.ir_write = 1'b1;
        step(1'b1, 1'b1, rb(), o);

        o = '0;
        if (kind == KJUMP || kind == KBR || kind == KRSVD) begin
            o.pc_write = 1'b1;
            o.retire   = 1'b1;
            o.pc_src   = (kind == KJUMP) ? 3'b010 : ((kind == KBR && taken) ? 3'b100 : 3'b001);
            step(1'b1, rb(), rb(), o);
            return;
        end
        step(1'b1, rb(), rb(), o);

        ex               = '0;
        ex.alu_op        = (kind == KR || kind == KI) ? 3'(fn) : 3'b000;
        ex.alu_src_const = (kind == KI || kind == KLOAD || kind == KSTORE);
        ex.rf_rd2_sel_rd = (kind == KSTORE);
        step(1'b1, rb(), rb(), ex);

        if (kind == KLOAD || kind == KSTORE) begin
            o           = ex;
            o.mem_read  = (kind == KLOAD);
            o.mem_write = (kind == KSTORE);
            for (int i = 0; i < mdel && i < int'(TO); i++) step(1'b1, rb(), 1'b0, o);
            if (abort) begin
                do_reset(2);
                return;
            end
            if (mdel >= int'(TO)) begin
                error_tail();
                return;
            end
            if (kind == KSTORE) begin
                o.pc_write = 1'b1;
                o.pc_src   = 3'b001;
                o.retire   = 1'b1;
            end
            step(1'b1, rb(), 1'b1, o);
            if (kind == KSTORE) return;
        end

        o                  = ex;
        o.rf_write_en      = 1'b1;
        o.rf_in_sel        = (kind == KLOAD) ? 3'b010 : ((kind == KSH) ? 3'b100 : 3'b001);
        o.flag_write       = (kind != KLOAD);
        o.flag_sel_shifter = (kind == KSH);
        o.pc_write         = 1'b1;
        o.pc_src           = 3'b001;
        o.retire           = 1'b1;
        step(1'b1, rb(), rb(), o);
    endtask

    task automatic fetch_idle();
        outs_t o;
        o          = '0;
        o.imem_req = 1'b1;
        step(1'b1, 1'b0, rb(), o);
    endtask

    initial begin
        bus.opcode     = '0;
        bus.c_flag     = 1'b0;
        bus.z_flag     = 1'b0;
        bus.imem_ready = 1'b0;
        bus.mem_ready  = 1'b0;
        do_reset(2);

        // R-ALU ADD with immediate ready
        run_instr(6'b000000, 1'b0, 1'b0, 0, 0, 1'b0);
        settle();
        lit("alu_len", last_len, 4);
        lit("alu_pc_src", int'(last_pc_src), 1);

        // LOAD with mem_ready low for 3 cycles
        run_instr(6'b100000, 1'b0, 1'b0, 0, 3, 1'b0);
        settle();
        lit("load_len", last_len, 8);
        lit("load_rf_in_sel", int'(last_rf_in_sel), 2);
        lit("count_after_two", int'(bus.retired_count), 1);

        // BRANCH Z taken / not taken, JUMP
        run_instr(6'b110000, 1'b0, 1'b1, 0, 0, 1'b0);
        settle();
        lit("branch_taken_pc_src", int'(last_pc_src), 4);
        lit("branch_len", last_len, 2);
        run_instr(6'b110000, 1'b0, 1'b0, 0, 0, 1'b0);
        settle();
        lit("branch_not_taken_pc_src", int'(last_pc_src), 1);
        run_instr(6'b101000, 1'b0, 1'b0, 0, 0, 1'b0);
        settle();
        lit("jump_pc_src", int'(last_pc_src), 2);
        lit("jump_len", last_len, 2);

        // Ready arriving on the very cycle the limit is reached still wins
        run_instr(6'b010110, 1'b0, 1'b0, int'(TO) - 1, 0, 1'b0);
        settle();
        lit("ready_at_limit_len", last_len, int'(TO) + 3);
        lit("ready_at_limit_error", int'(bus.error), 0);

        // Fetch timeout, then reset
        run_instr(6'b000010, 1'b0, 1'b0, int'(TO), 0, 1'b0);
        settle();
        lit("fetch_timeout_error", int'(bus.error), 1);
        do_reset(2);
        settle();
        lit("error_cleared_by_reset", int'(bus.error), 0);

        // Data-memory timeout
        run_instr(6'b100000, 1'b0, 1'b0, 0, int'(TO), 1'b0);
        settle();
        lit("mem_timeout_error", int'(bus.error), 1);
        do_reset(1);

        // Reset in the middle of a STORE's MEM wait
        run_instr(6'b100010, 1'b0, 1'b0, 0, 2, 1'b1);
        settle();
        lit("abort_mem_write", int'(bus.mem_write), 0);
        lit("abort_no_retire", int'(bus.retire), 0);
        run_instr(6'b100010, 1'b0, 1'b0, 1, 1, 1'b0);
        settle();
        lit("store_after_abort_len", last_len, 6);

        // Counter wrap via reserved-opcode NOPs
        do_reset(1);
        for (int i = 0; i < (1 << RW) - 1; i++) run_instr(6'b100110, rb(), rb(), 0, 0, 1'b0);
        fetch_idle();
        settle();
        lit("count_at_max", int'(bus.retired_count), (1 << RW) - 1);
        run_instr(6'b100110, 1'b0, 1'b0, 0, 0, 1'b0);
        fetch_idle();
        settle();
        lit("count_wrapped", int'(bus.retired_count), 0);

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            int fd, md;
            fd = ($urandom_range(0, 15) == 0) ? int'(TO) - 1 : int'($urandom_range(0, 3));
            md = int'($urandom_range(0, 4));
            if ($urandom_range(0, 39) == 0) do_reset(1);
            run_instr(6'($urandom), rb(), rb(), fd, md, 1'b0);
        end

        settle();
        settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
